// File: rtl/mem_port_arb_pkg.sv
// rtl/mem_port_arb_pkg.sv - shared constants and types for the memory port arbiter
package mem_port_arb_pkg;

   localparam int DEF_ADDR_W     = 32;
   localparam int DEF_DATA_W     = 32;
   localparam int DEF_MAX_OUT    = 4;
   localparam int DEF_STARVE_MAX = 8;

   // Source tags stored per outstanding read
   localparam logic PORT_LSU = 1'b0;
   localparam logic PORT_IF  = 1'b1;

   typedef enum logic {
      NORMAL = 1'b0,
      AGED   = 1'b1
   } arb_mode_t;

endpackage

// File: rtl/mem_port_arb_if.sv
// rtl/mem_port_arb_if.sv - requester, memory and response signals of the shared memory port
interface mem_port_arb_if
   import mem_port_arb_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
) ();

   logic              req0_v, req1_v;
   logic [ADDR_W-1:0] req0_addr, req1_addr;
   logic              req0_we, req1_we;
   logic [DATA_W-1:0] req0_wdata, req1_wdata;
   logic              req0_rdy, req1_rdy;

   logic              m_v;
   logic [ADDR_W-1:0] m_addr;
   logic              m_we;
   logic [DATA_W-1:0] m_wdata;
   logic              m_rdy;
   logic              m_rv;
   logic [DATA_W-1:0] m_rdata;

   logic              rsp0_v, rsp1_v;
   logic [DATA_W-1:0] rsp_data;

   // Arbiter side
   modport slave (
      input  req0_v, req0_addr, req0_we, req0_wdata,
      input  req1_v, req1_addr, req1_we, req1_wdata,
      input  m_rdy, m_rv, m_rdata,
      output req0_rdy, req1_rdy,
      output m_v, m_addr, m_we, m_wdata,
      output rsp0_v, rsp1_v, rsp_data
   );

   // Requesters and memory side
   modport master (
      output req0_v, req0_addr, req0_we, req0_wdata,
      output req1_v, req1_addr, req1_we, req1_wdata,
      output m_rdy, m_rv, m_rdata,
      input  req0_rdy, req1_rdy,
      input  m_v, m_addr, m_we, m_wdata,
      input  rsp0_v, rsp1_v, rsp_data
   );

endinterface

// File: rtl/mem_port_arb_tag_fifo.sv
// rtl/mem_port_arb_tag_fifo.sv - synchronous in-order FIFO holding source tags of outstanding reads
module tag_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   push,
   input  logic [WIDTH-1:0]       push_data,
   input  logic                   pop,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count,
   output logic [WIDTH-1:0]       head
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic             do_push, do_pop;

   // Full is judged on the count at cycle start, so a simultaneous pop does not free a slot early
   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr];

   // Pointers wrap naturally because DEPTH is a power of two
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   // Tag storage needs no reset; entries are only read while counted valid
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/mem_port_arb.sv
// rtl/mem_port_arb.sv - two-port arbiter with aging and in-order response routing for the memory port
module mem_port_arb
   import mem_port_arb_pkg::*;
#(
   parameter int ADDR_W     = DEF_ADDR_W,
   parameter int DATA_W     = DEF_DATA_W,
   parameter int MAX_OUT    = DEF_MAX_OUT,
   parameter int STARVE_MAX = DEF_STARVE_MAX
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          pause,
   mem_port_arb_if.slave bus,
   output logic          busy,
   output logic          err
);

   localparam int CNT_W  = $clog2(STARVE_MAX + 1);
   localparam int OUT_CW = $clog2(MAX_OUT) + 1;
   localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

   arb_mode_t        mode, mode_nxt;
   logic [CNT_W-1:0] starve_cnt;
   logic             full, empty, head;
   logic [OUT_CW-1:0] tag_count;
   logic             elig0, elig1, aged, sel0, sel1, acc1, push, pop;

   // Writes push no tag, so they stay eligible while the tag FIFO is full
   assign elig0 = !pause && bus.req0_v && (bus.req0_we || !full);
   assign elig1 = !pause && bus.req1_v && (bus.req1_we || !full);

   // Aging takes effect in the very cycle the counter saturates
   assign aged = (mode == AGED) || (starve_cnt == STARVE_LIM);
   assign sel1 = elig1 && (aged || !elig0);
   assign sel0 = elig0 && !sel1;

   assign bus.req0_rdy = sel0 && bus.m_rdy;
   assign bus.req1_rdy = sel1 && bus.m_rdy;
   assign acc1         = bus.req1_rdy;

   // Mux the granted port onto the memory request bus; fields are zero when idle
   always_comb begin
      bus.m_v     = 1'b0;
      bus.m_addr  = '0;
      bus.m_we    = 1'b0;
      bus.m_wdata = '0;
      if (sel1) begin
         bus.m_v     = 1'b1;
         bus.m_addr  = bus.req1_addr;
         bus.m_we    = bus.req1_we;
         bus.m_wdata = bus.req1_wdata;
      end else if (sel0) begin
         bus.m_v     = 1'b1;
         bus.m_addr  = bus.req0_addr;
         bus.m_we    = bus.req0_we;
         bus.m_wdata = bus.req0_wdata;
      end
   end

   assign push = (sel0 || sel1) && bus.m_rdy && !bus.m_we;
   assign pop  = bus.m_rv && !empty;

   tag_fifo #(
      .DEPTH (MAX_OUT),
      .WIDTH (1)
   ) u_tags (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .push_data (sel1 ? PORT_IF : PORT_LSU),
      .pop       (pop),
      .full      (full),
      .empty     (empty),
      .count     (tag_count),
      .head      (head)
   );

   assign bus.rsp0_v   = pop && (head == PORT_LSU);
   assign bus.rsp1_v   = pop && (head == PORT_IF);
   assign bus.rsp_data = bus.m_rdata;
   assign busy         = (tag_count != '0);

   // Arbitration mode register
   always_ff @(posedge clk) begin
      if (reset) mode <= NORMAL;
      else       mode <= mode_nxt;
   end

   // Enter AGED on saturation, leave once fetch has been served
   always_comb begin
      mode_nxt = mode;
      case (mode)
         NORMAL: if (starve_cnt == STARVE_LIM && !acc1) mode_nxt = AGED;
         AGED:   if (acc1) mode_nxt = NORMAL;
         default: mode_nxt = NORMAL;
      endcase
   end

   // Count consecutive denied fetch cycles; frozen while paused
   always_ff @(posedge clk) begin
      if (reset || !bus.req1_v || acc1) begin
         starve_cnt <= '0;
      end else if (!pause && starve_cnt != STARVE_LIM) begin
         starve_cnt <= starve_cnt + 1'b1;
      end
   end

   // Sticky flag for a response arriving with no read outstanding
   always_ff @(posedge clk) begin
      if (reset)                  err <= 1'b0;
      else if (bus.m_rv && empty) err <= 1'b1;
   end

endmodule

// File: tb/tb_mem_port_arb.sv
// tb/tb_mem_port_arb.sv - directed self-checking bench for mem_port_arb
module tb_mem_port_arb;

   localparam int AW = 32;
   localparam int DW = 32;

   logic clk = 1'b0;
   logic reset;
   logic pause;
   logic busy;
   logic err;
   int   n_checks = 0;
   int   n_fail   = 0;

   mem_port_arb_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   mem_port_arb #(
      .ADDR_W     (AW),
      .DATA_W     (DW),
      .MAX_OUT    (4),
      .STARVE_MAX (8)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .pause (pause),
      .bus   (bus.slave),
      .busy  (busy),
      .err   (err)
   );

   always #5 clk = ~clk;

   task automatic idle();
      pause          = 1'b0;
      bus.req0_v     = 1'b0;
      bus.req0_addr  = '0;
      bus.req0_we    = 1'b0;
      bus.req0_wdata = '0;
      bus.req1_v     = 1'b0;
      bus.req1_addr  = '0;
      bus.req1_we    = 1'b0;
      bus.req1_wdata = '0;
      bus.m_rdy      = 1'b0;
      bus.m_rv       = 1'b0;
      bus.m_rdata    = '0;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      next_cycle();
      idle();
      reset = 1'b1;
      next_cycle();
      next_cycle();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      idle();
      next_cycle();
      @(negedge clk);
      n_checks++;
      if ({bus.m_v, bus.req0_rdy, bus.req1_rdy, bus.rsp0_v, bus.rsp1_v, busy, err} !== 7'b0) begin
         n_fail++;
         $display("FAIL reset_outputs got %b expected 0000000",
                  {bus.m_v, bus.req0_rdy, bus.req1_rdy, bus.rsp0_v, bus.rsp1_v, busy, err});
      end
      reset = 1'b0;
   endtask

   task automatic test_port0_reads();
      logic [5:0]    exp_busy = 6'b011110;
      logic [DW-1:0] exp_data;
      int            rsp_cnt = 0;
      do_reset();
      for (int c = 1; c <= 6; c++) begin
         next_cycle();
         bus.req0_v     = (c <= 3);
         bus.req0_addr  = 32'h100 + 32'(4 * (c - 1));
         bus.req0_we    = 1'b0;
         bus.m_rdy      = 1'b1;
         bus.m_rv       = (c >= 3 && c <= 5);
         bus.m_rdata    = 32'hA1 + 32'(c - 3);
         exp_data       = 32'hA1 + 32'(c - 3);
         @(negedge clk);
         n_checks++;
         if (bus.req0_rdy !== (c <= 3)) begin
            n_fail++;
            $display("FAIL p0_rdy c=%0d got %b expected %b", c, bus.req0_rdy, (c <= 3));
         end
         if (c <= 3) begin
            n_checks++;
            if (bus.m_addr !== 32'h100 + 32'(4 * (c - 1)) || bus.m_v !== 1'b1) begin
               n_fail++;
               $display("FAIL p0_maddr c=%0d got %h v=%b", c, bus.m_addr, bus.m_v);
            end
         end
         if (c >= 3 && c <= 5) begin
            n_checks++;
            if ({bus.rsp0_v, bus.rsp1_v, bus.rsp_data} !== {2'b10, exp_data}) begin
               n_fail++;
               $display("FAIL p0_rsp c=%0d got %b%b %h expected 10 %h",
                        c, bus.rsp0_v, bus.rsp1_v, bus.rsp_data, exp_data);
            end
         end
         if (bus.rsp0_v === 1'b1) rsp_cnt++;
         n_checks++;
         if (busy !== exp_busy[c-1]) begin
            n_fail++;
            $display("FAIL p0_busy c=%0d got %b expected %b", c, busy, exp_busy[c-1]);
         end
      end
      n_checks++;
      if (rsp_cnt != 3) begin
         n_fail++;
         $display("FAIL p0_rsp_count got %0d expected 3", rsp_cnt);
      end
   endtask

   task automatic test_aging();
      logic exp0, exp1, exp_r1;
      do_reset();
      for (int c = 1; c <= 12; c++) begin
         next_cycle();
         bus.req0_v    = (c <= 10);
         bus.req1_v    = (c <= 10);
         bus.req0_we   = 1'b0;
         bus.req1_we   = 1'b0;
         bus.req0_addr = 32'h2000 + 32'(c);
         bus.req1_addr = 32'h3000 + 32'(c);
         bus.m_rdy     = 1'b1;
         bus.m_rv      = (c >= 2 && c <= 11);
         bus.m_rdata   = 32'h5500 + 32'(c);
         @(negedge clk);
         exp0   = (c <= 10) && (c != 9);
         exp1   = (c == 9);
         exp_r1 = (c == 10);
         n_checks++;
         if ({bus.req0_rdy, bus.req1_rdy} !== {exp0, exp1}) begin
            n_fail++;
            $display("FAIL age_grant c=%0d got %b%b expected %b%b",
                     c, bus.req0_rdy, bus.req1_rdy, exp0, exp1);
         end
         if (c >= 2 && c <= 11) begin
            n_checks++;
            if ({bus.rsp0_v, bus.rsp1_v} !== {!exp_r1, exp_r1}) begin
               n_fail++;
               $display("FAIL age_rsp c=%0d got %b%b expected %b%b",
                        c, bus.rsp0_v, bus.rsp1_v, !exp_r1, exp_r1);
            end
         end
      end
      n_checks++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL age_busy got %b expected 0", busy);
      end
   endtask

   task automatic test_full();
      logic [12:0] exp_rdy = 13'b0000010101111;
      do_reset();
      for (int c = 1; c <= 13; c++) begin
         next_cycle();
         bus.req0_v    = (c <= 8);
         bus.req0_we   = (c == 6);
         bus.req0_addr = 32'h400 + 32'(c);
         bus.m_rdy     = 1'b1;
         bus.m_rv      = (c == 7) || (c >= 9 && c <= 12);
         bus.m_rdata   = 32'h7700 + 32'(c);
         @(negedge clk);
         n_checks++;
         if (bus.req0_rdy !== exp_rdy[c-1]) begin
            n_fail++;
            $display("FAIL full_rdy c=%0d got %b expected %b", c, bus.req0_rdy, exp_rdy[c-1]);
         end
         if (c == 5) begin
            n_checks++;
            if (bus.m_v !== 1'b0) begin
               n_fail++;
               $display("FAIL full_mv got %b expected 0", bus.m_v);
            end
         end
         if (c == 6) begin
            n_checks++;
            if (bus.m_we !== 1'b1) begin
               n_fail++;
               $display("FAIL full_write got we=%b expected 1", bus.m_we);
            end
         end
         if (bus.m_rv) begin
            n_checks++;
            if ({bus.rsp0_v, bus.rsp1_v} !== 2'b10) begin
               n_fail++;
               $display("FAIL full_rsp c=%0d got %b%b expected 10", c, bus.rsp0_v, bus.rsp1_v);
            end
         end
      end
      n_checks++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL full_busy got %b expected 0", busy);
      end
   endtask

   task automatic test_interleave();
      logic [1:0]    exp_rsp;
      logic [DW-1:0] exp_data;
      do_reset();
      for (int c = 1; c <= 6; c++) begin
         next_cycle();
         bus.req0_v  = (c == 1) || (c == 3);
         bus.req1_v  = (c == 2);
         bus.req0_we = 1'b0;
         bus.req1_we = 1'b0;
         bus.m_rdy   = 1'b1;
         bus.m_rv    = (c >= 4);
         case (c)
            4:       begin exp_data = 32'h11; exp_rsp = 2'b10; end
            5:       begin exp_data = 32'h22; exp_rsp = 2'b01; end
            6:       begin exp_data = 32'h33; exp_rsp = 2'b10; end
            default: begin exp_data = 32'h0;  exp_rsp = 2'b00; end
         endcase
         bus.m_rdata = exp_data;
         @(negedge clk);
         n_checks++;
         if ({bus.req0_rdy, bus.req1_rdy} !== {(c == 1 || c == 3), (c == 2)}) begin
            n_fail++;
            $display("FAIL il_grant c=%0d got %b%b", c, bus.req0_rdy, bus.req1_rdy);
         end
         if (c >= 4) begin
            n_checks++;
            if ({bus.rsp0_v, bus.rsp1_v, bus.rsp_data} !== {exp_rsp, exp_data}) begin
               n_fail++;
               $display("FAIL il_rsp c=%0d got %b%b %h expected %b %h",
                        c, bus.rsp0_v, bus.rsp1_v, bus.rsp_data, exp_rsp, exp_data);
            end
         end
      end
   endtask

   task automatic test_pause();
      do_reset();
      for (int c = 0; c <= 14; c++) begin
         next_cycle();
         pause       = (c >= 4 && c <= 8);
         bus.req0_v  = (c >= 1);
         bus.req0_we = 1'b1;
         bus.req1_v  = 1'b1;
         bus.req1_we = (c >= 1);
         bus.m_rdy   = 1'b1;
         bus.m_rv    = (c == 6);
         bus.m_rdata = 32'h66;
         @(negedge clk);
         if (c == 0) begin
            n_checks++;
            if (bus.req1_rdy !== 1'b1) begin
               n_fail++;
               $display("FAIL pause_setup got %b expected 1", bus.req1_rdy);
            end
         end else if (c >= 4 && c <= 8) begin
            n_checks++;
            if ({bus.req0_rdy, bus.req1_rdy, bus.m_v} !== 3'b000) begin
               n_fail++;
               $display("FAIL pause_block c=%0d got %b%b%b expected 000",
                        c, bus.req0_rdy, bus.req1_rdy, bus.m_v);
            end
            if (c == 6) begin
               n_checks++;
               if ({bus.rsp0_v, bus.rsp1_v} !== 2'b01) begin
                  n_fail++;
                  $display("FAIL pause_rsp got %b%b expected 01", bus.rsp0_v, bus.rsp1_v);
               end
            end
         end else begin
            n_checks++;
            if ({bus.req0_rdy, bus.req1_rdy} !== {(c != 14), (c == 14)}) begin
               n_fail++;
               $display("FAIL pause_starve c=%0d got %b%b expected %b%b",
                        c, bus.req0_rdy, bus.req1_rdy, (c != 14), (c == 14));
            end
         end
      end
   endtask

   task automatic test_err_reset();
      do_reset();
      for (int c = 1; c <= 5; c++) begin
         next_cycle();
         bus.m_rv    = (c == 1);
         bus.m_rdy   = 1'b1;
         bus.req0_v  = (c == 3);
         bus.req1_v  = (c == 4);
         bus.req0_we = 1'b0;
         bus.req1_we = 1'b0;
         @(negedge clk);
         n_checks++;
         if (err !== (c >= 2)) begin
            n_fail++;
            $display("FAIL err_sticky c=%0d got %b expected %b", c, err, (c >= 2));
         end
         if (c == 1) begin
            n_checks++;
            if ({bus.rsp0_v, bus.rsp1_v} !== 2'b00) begin
               n_fail++;
               $display("FAIL err_norsp got %b%b expected 00", bus.rsp0_v, bus.rsp1_v);
            end
         end
      end
      n_checks++;
      if (busy !== 1'b1) begin
         n_fail++;
         $display("FAIL err_busy_pre got %b expected 1", busy);
      end
      next_cycle();
      idle();
      reset = 1'b1;
      next_cycle();
      reset = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({busy, err} !== 2'b00) begin
         n_fail++;
         $display("FAIL mid_reset got busy=%b err=%b expected 0 0", busy, err);
      end
   endtask

   initial begin
      reset = 1'b1;
      idle();
      test_reset();
      test_port0_reads();
      test_aging();
      test_full();
      test_interleave();
      test_pause();
      test_err_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_port_arb.md
# mem_port_arb

Two-requester arbiter and sequencer for the core's single shared memory port. Arbitrates between the data path (port 0, load/store unit) and instruction fetch (port 1) with valid/ready handshakes. Tracks outstanding reads in an in-order source-tag FIFO so each returning response is routed to the port that issued it. Bounds fetch starvation with an aging counter.

## Interface
- `ADDR_W`, default 32: request address width.
- `DATA_W`, default 32: write and read data width.
- `MAX_OUT`, default 4: maximum outstanding reads (power of 2, ≥2).
- `STARVE_MAX`, default 8: number of consecutive denied fetch cycles that forces a fetch grant.

Ports:
- `clk` in 1: single clock, all state on posedge.
- `reset` in 1: synchronous, active-high.
- `pause` in 1: pipeline freeze. No new grants while it is high; responses are still delivered.
- `req0_v`, `req1_v` in 1: request valid. Held stable until accepted.
- `req0_addr`, `req1_addr` in ADDR_W: request address.
- `req0_we`, `req1_we` in 1: 1 = write, 0 = read.
- `req0_wdata`, `req1_wdata` in DATA_W: write data.
- `req0_rdy`, `req1_rdy` out 1: request accepted this cycle.
- `m_v` out 1: request valid to memory.
- `m_addr` out ADDR_W, `m_we` out 1, `m_wdata` out DATA_W: the muxed request fields.
- `m_rdy` in 1: memory accepts the request.
- `m_rv` in 1, `m_rdata` in DATA_W: read response. Responses return in order; writes produce no response.
- `rsp0_v`, `rsp1_v` out 1: response valid to port 0 / port 1.
- `rsp_data` out DATA_W: equals `m_rdata`.
- `busy` out 1: at least one read is outstanding.
- `err` out 1: sticky flag. Set on `m_rv` while the tag FIFO is empty.

## Operation
- Grant eligibility: `!pause & !full`. Writes are also eligible when the FIFO is full, because they push nothing.
- Grant selection:
  - Mode NORMAL: port 0 has fixed priority.
  - Mode AGED: entered when `starve_cnt == STARVE_MAX`. Port 1 wins if `req1_v`. Exits to NORMAL on a port-1 grant.
- `starve_cnt`:
  - Increments, saturating at STARVE_MAX, on each cycle with `req1_v & !req1_rdy & !pause`.
  - Clears on a port-1 acceptance or when `req1_v` is low.
- Driving memory:
  - `m_v` and the m_* fields are taken from the selected port; they are 0 when nothing is eligible.
  - `reqN_rdy = selN & m_rdy`. The request is accepted when `reqN_v & reqN_rdy`.
- Accepted read: pushes the source bit (0/1) into the tag FIFO.
- `m_rv`:
  - Pops the FIFO head.
  - Drives `rsp0_v` or `rsp1_v` combinationally from the head bit.
  - If `m_rv` arrives with the FIFO empty: `err` is set, both rsp_v stay 0, and no pop occurs.
- Same-cycle push and pop: both take effect and the count is unchanged. `full` is evaluated before the pop, so a push is blocked when the FIFO is full at cycle start.
- Pointer wrap: wrap modulo MAX_OUT; count width is clog2(MAX_OUT)+1.

## Timing
- Request path is 0-cycle combinational (reqN → m_*). Grant lands in the same cycle as `m_rdy`.
- Response routing is 0-cycle combinational (`m_rv` → `rspN_v`).
- Tag FIFO and `starve_cnt` update on the posedge after the event.
- `pause` blocks grants in the same cycle. `starve_cnt` holds during `pause`.
- Reset values:
  - Outputs: `m_v`=0, `reqN_rdy`=0, `rspN_v`=0, `busy`=0, `err`=0.
  - State: FIFO empty, `starve_cnt`=0, mode NORMAL.
- Reset mid-operation: all in-flight tags are discarded. Memory is reset on the same `reset`, so no stale responses are expected.

## Structure
- Shared package holds:
  - `PORT_LSU`=0 and `PORT_IF`=1.
  - `arb_mode_t` {NORMAL, AGED}.
  - Default widths.
- Sub-module `tag_fifo`:
  - Parameterised depth and width, synchronous.
  - Outputs: full, empty, count, head.
  - Instantiated with width 1.
- The top level contains the arbitration logic, the aging counter and the `err` register.

## Test plan
- Port 0 only, 3 reads, `m_rdy`=1, responses 2 cycles later with data 0xA1..0xA3 → `rsp0_v` asserted 3 times with data in order, `busy` falls after the last response.
- Both ports continuously requesting reads, `m_rdy`=1, fast responses, STARVE_MAX=8 → port 1 granted on the 9th cycle. Then port 0 resumes.
- MAX_OUT=4, 4 reads issued with no response → the 5th read sees `rdy`=0. A write is still accepted. One `m_rv` in the same cycle as a new read: the read is blocked that cycle and accepted the next.
- Interleaved reads port0, port1, port0 with responses 0x11, 0x22, 0x33 → `rsp0_v`, `rsp1_v`, `rsp0_v` with the matching data.
- `pause` held 5 cycles while both ports request → no `rdy` asserted, `starve_cnt` frozen, pending `m_rv` still routed.
- `m_rv` asserted with the FIFO empty → `err`=1 and sticky. `reset` mid-stream with 2 outstanding → `busy`=0 and `err`=0 the next cycle.
